hdmi_fb_rd_sched: RTL and testbench
===================================

// Module: hdmi_fb_rd_sched
// PURPOSE
//  Read-side scheduler between the SDRAM frame buffer and the HDMI video path.
//  Issues burst read requests to the SDRAM controller read port to keep the display line FIFO ahead of video_driver's data_req.
//  Selects the ping-pong frame bank at each frame start so the display never reads the bank the camera writer is filling.
//  Runs entirely in the pixel_clk domain; the FIFO and SDRAM port sit in this domain or present synchronised handshakes.
// PARAMETERS
//  H_ACT       1280     active pixels per line
//  V_ACT       720      active lines per frame
//  BURST       256      max words per read burst
//  FIFO_DEPTH  1024     display FIFO depth, words
//  LVL_W       11       width of FIFO level bus
//  OFS_W       20       word-offset width within one bank (H_ACT*V_ACT <= 2**OFS_W)
//  VS_POL      1        active level of video_vs
//  FLUSH_CYC   4        cycles fifo_clr is held at frame start
// PORTS
//  pixel_clk     in   1          clock
//  sys_rst       in   1          asynchronous reset, active-high
//  video_vs      in   1          vertical sync from video_driver
//  wr_frame_done in   1          1-cycle pulse: writer completed a frame in bank wr_bank
//  wr_bank       in   1          bank the writer is currently filling / just completed
//  fifo_level    in   LVL_W      display FIFO used words
//  fifo_clr      out  1          FIFO flush at frame start
//  rd_req        out  1          burst request; held until rd_ack
//  rd_ack        in   1          controller accepted request (1 cycle)
//  rd_done       in   1          1-cycle pulse: last word of accepted burst written to FIFO
//  rd_addr       out  OFS_W+1    {bank, word offset}; stable while rd_req=1
//  rd_len        out  9          burst length, 1..BURST; stable while rd_req=1
//  rd_bank       out  1          bank being displayed this frame
//  underrun      out  1          1-cycle pulse: frame start before previous frame fully fetched
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; offset 0; rd_bank 0; ready_bank 0; ready_vld 0.
//  Frame start = rising edge of (video_vs==VS_POL), registered edge detect (1-cycle latency).
//  Bank tracking: wr_frame_done latches ready_bank<=wr_bank, ready_vld<=1.
//   At FLUSH entry: if ready_vld and ready_bank!=wr_bank then rd_bank<=ready_bank, ready_vld<=0; else rd_bank unchanged (repeat frame).
//   wr_frame_done coincident with frame start: new ready_bank used in same FLUSH.
//  FSM:
//   IDLE  : wait first frame start -> FLUSH.
//   FLUSH : fifo_clr=1 for FLUSH_CYC cycles; offset<=0 -> CHECK.
//   CHECK : remaining=H_ACT*V_ACT-offset; len=min(BURST,remaining);
//           remaining==0 -> DONE; fifo_level+len <= FIFO_DEPTH -> REQ (rd_req set next cycle); else stay.
//   REQ   : rd_req=1, rd_addr={rd_bank,offset}, rd_len=len; on rd_ack -> rd_req=0, WAIT.
//   WAIT  : on rd_done offset<=offset+rd_len -> CHECK (earliest next rd_req 2 cycles after rd_done).
//   DONE  : idle until frame start -> FLUSH.
//  Frame start in REQ (no ack yet): drop rd_req same edge, underrun pulse, -> FLUSH.
//  rd_ack coincident with frame start in REQ: treat as accepted -> WAIT with pend_flush=1.
//  Frame start in WAIT: set pend_flush, underrun pulse; burst completes (cannot abort SDRAM), then on rd_done -> FLUSH.
//  Frame start in CHECK: underrun pulse -> FLUSH. In DONE: no underrun.
//  rd_done/rd_ack outside WAIT/REQ ignored. Offset arithmetic OFS_W bits, never exceeds H_ACT*V_ACT.
//  sys_rst mid-burst: immediate return to reset state; controller side must discard its in-flight burst.
// STRUCTURE
//  Shared package hdmi_pkg: H_ACT/V_ACT/BURST constants, state encoding typedef, FRAME_WORDS = H_ACT*V_ACT.
//  One sub-module: fb_bank_sel (ready_bank/ready_vld tracking and rd_bank select on FLUSH strobe).
//  FSM, edge detect, offset counter and length min() stay in top.
// TESTING
//  Reset, then frame start with fifo_level=0 -> fifo_clr 4 cycles, rd_req with addr 0, len 256.
//  Full frame, instant ack/done, level 0 -> 3600 bursts, last addr offset 921344 len 256, then DONE, no underrun.
//  fifo_level=900 in CHECK -> no rd_req until level<=768; drop to 768 -> rd_req next cycle.
//  wr_frame_done wr_bank=1 then writer switches to bank 0 -> next frame rd_bank=1; no done pulse -> rd_bank repeats.
//  Frame start during WAIT at offset 512 -> underrun pulse, rd_req stays 0 until rd_done, then fifo_clr, restart at offset 0.
//  Frame start in REQ without ack -> rd_req drops same cycle, underrun=1, fifo_clr follows.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared constants and state encoding for the HDMI frame-buffer read scheduler.
package hdmi_pkg;

  localparam int H_ACT       = 1280;
  localparam int V_ACT       = 720;
  localparam int BURST       = 256;
  localparam int FIFO_DEPTH  = 1024;
  localparam int LVL_W       = 11;
  localparam int OFS_W       = 20;
  localparam int LEN_W       = 9;
  localparam logic VS_POL    = 1'b1;
  localparam int FLUSH_CYC   = 4;
  localparam int FRAME_WORDS = H_ACT * V_ACT;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/hdmi_fb_rd_sched_if.sv
// SDRAM controller read-port handshake: burst request, acceptance and completion.
interface hdmi_fb_rd_sched_if;
  import hdmi_pkg::*;

  logic             rd_req;
  logic             rd_ack;
  logic             rd_done;
  logic [OFS_W:0]   rd_addr;
  logic [LEN_W-1:0] rd_len;

  modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
  modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);

endinterface

// File: rtl/hdmi_fb_rd_sched_fb_bank_sel.sv
// Ping-pong bank tracker: remembers the last completed write bank and hands it
// to the display at frame start, unless the writer is already refilling it.
module fb_bank_sel (
  input  logic clk,
  input  logic rst,
  input  logic wr_frame_done,
  input  logic wr_bank,
  input  logic sel_stb,
  output logic rd_bank
);

  logic ready_bank_reg, ready_vld_reg, rd_bank_reg;
  logic cand_bank, cand_vld, take;

  // A completion arriving on the same cycle as the strobe is already visible here.
  assign cand_bank = wr_frame_done ? wr_bank : ready_bank_reg;
  assign cand_vld  = wr_frame_done | ready_vld_reg;
  assign take      = sel_stb & cand_vld & (cand_bank != wr_bank);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_bank_reg <= 1'b0;
      ready_vld_reg  <= 1'b0;
      rd_bank_reg    <= 1'b0;
    end else begin
      ready_bank_reg <= cand_bank;
      ready_vld_reg  <= cand_vld & ~take;
      if (take) rd_bank_reg <= cand_bank;
    end
  end

  assign rd_bank = rd_bank_reg;

endmodule

// File: rtl/hdmi_fb_rd_sched.sv
// Read-side scheduler: issues SDRAM burst reads that keep the display FIFO ahead
// of the video path, restarting at every frame start on the selected bank.
module hdmi_fb_rd_sched
  import hdmi_pkg::*;
(
  input  logic                 pixel_clk,
  input  logic                 sys_rst,
  input  logic                 video_vs,
  input  logic                 wr_frame_done,
  input  logic                 wr_bank,
  input  logic [LVL_W-1:0]     fifo_level,
  output logic                 fifo_clr,
  hdmi_fb_rd_sched_if.master   rd,
  output logic                 rd_bank,
  output logic                 underrun
);

  localparam int CNT_W = $clog2(FLUSH_CYC);
  localparam logic [OFS_W-1:0] FRAME_W = OFS_W'(FRAME_WORDS);

  rd_state_t        state_reg, state_next;
  logic [OFS_W-1:0] offset_reg, offset_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             underrun_reg, underrun_next;
  logic             vs_d_reg, fs_reg;
  logic             vs_act, flush_entry, fits;
  logic [OFS_W-1:0] remaining;
  logic [LEN_W-1:0] burst_len;

  assign vs_act = (video_vs == VS_POL);

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_d_reg <= 1'b0;
      fs_reg   <= 1'b0;
    end else begin
      vs_d_reg <= vs_act;
      fs_reg   <= vs_act & ~vs_d_reg;
    end
  end

  assign remaining = FRAME_W - offset_reg;
  assign burst_len = (remaining >= OFS_W'(BURST)) ? LEN_W'(BURST) : remaining[LEN_W-1:0];
  assign fits      = ({1'b0, fifo_level} + 12'(burst_len)) <= 12'(FIFO_DEPTH);

  always_comb begin
    state_next    = state_reg;
    offset_next   = offset_reg;
    len_next      = len_reg;
    cnt_next      = cnt_reg;
    pend_next     = pend_reg;
    underrun_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: if (fs_reg) state_next = ST_FLUSH;
      ST_FLUSH: begin
        offset_next = '0;
        pend_next   = 1'b0;
        if (cnt_reg == CNT_W'(FLUSH_CYC - 1)) state_next = ST_CHECK;
        else cnt_next = cnt_reg + 1'b1;
      end
      ST_CHECK: begin
        if (fs_reg) begin
          underrun_next = 1'b1;
          state_next    = ST_FLUSH;
        end else if (remaining == '0) begin
          state_next = ST_DONE;
        end else if (fits) begin
          len_next   = burst_len;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        underrun_next = fs_reg;
        if (rd.rd_ack) begin
          pend_next  = fs_reg;
          state_next = ST_WAIT;
        end else if (fs_reg) begin
          state_next = ST_FLUSH;
        end
      end
      ST_WAIT: begin
        // An accepted burst cannot be aborted, so a new frame waits for rd_done.
        underrun_next = fs_reg;
        if (rd.rd_done) begin
          offset_next = offset_reg + OFS_W'(len_reg);
          state_next  = (pend_reg | fs_reg) ? ST_FLUSH : ST_CHECK;
        end else if (fs_reg) begin
          pend_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    flush_entry = (state_next == ST_FLUSH) && (state_reg != ST_FLUSH);
    if (flush_entry) cnt_next = '0;
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      offset_reg   <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      pend_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      offset_reg   <= offset_next;
      len_reg      <= len_next;
      cnt_reg      <= cnt_next;
      pend_reg     <= pend_next;
      underrun_reg <= underrun_next;
    end
  end

  fb_bank_sel u_bank_sel (
    .clk           (pixel_clk),
    .rst           (sys_rst),
    .wr_frame_done (wr_frame_done),
    .wr_bank       (wr_bank),
    .sel_stb       (flush_entry),
    .rd_bank       (rd_bank)
  );

  assign fifo_clr   = (state_reg == ST_FLUSH);
  assign rd.rd_req  = (state_reg == ST_REQ);
  assign rd.rd_addr = {rd_bank, offset_reg};
  assign rd.rd_len  = len_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_hdmi_fb_rd_sched.sv
// Directed bench for hdmi_fb_rd_sched: flush timing, level throttling, frame-start
// corner cases, bank selection and a full 720p frame fetch.
module tb_hdmi_fb_rd_sched;
  import hdmi_pkg::*;

  logic             pixel_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             video_vs = 1'b0;
  logic             wr_frame_done = 1'b0;
  logic             wr_bank = 1'b0;
  logic [LVL_W-1:0] fifo_level = '0;
  logic             fifo_clr, rd_bank, underrun;

  int n_checks = 0;
  int n_pass = 0;

  hdmi_fb_rd_sched_if rd_if ();

  hdmi_fb_rd_sched dut (
    .pixel_clk     (pixel_clk),
    .sys_rst       (sys_rst),
    .video_vs      (video_vs),
    .wr_frame_done (wr_frame_done),
    .wr_bank       (wr_bank),
    .fifo_level    (fifo_level),
    .fifo_clr      (fifo_clr),
    .rd            (rd_if),
    .rd_bank       (rd_bank),
    .underrun      (underrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Ends one negedge after vs rose; the scheduler reacts at the following edge.
  task automatic vs_pulse();
    @(negedge pixel_clk) video_vs = 1'b1;
    @(negedge pixel_clk) video_vs = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!rd_if.rd_req && n < 50) begin
      @(negedge pixel_clk);
      n++;
    end
    check(tag, 32'(rd_if.rd_req), 32'd1);
  endtask

  task automatic burst(input logic give_done);
    $display("burst addr=%0d len=%0d bank=%0d done=%0d", rd_if.rd_addr, rd_if.rd_len, rd_bank, give_done);
    rd_if.rd_ack = 1'b1;
    @(negedge pixel_clk) rd_if.rd_ack = 1'b0;
    if (give_done) begin
      rd_if.rd_done = 1'b1;
      @(negedge pixel_clk) rd_if.rd_done = 1'b0;
    end
  endtask

  initial begin
    int clr_cnt, req_at, seen, nb, bad, urun;
    logic [31:0] last_addr, last_len;
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;

    repeat (3) @(negedge pixel_clk);
    check("rst_fifo_clr", 32'(fifo_clr), 32'd0);
    check("rst_rd_req", 32'(rd_if.rd_req), 32'd0);
    check("rst_rd_addr", 32'(rd_if.rd_addr), 32'd0);
    check("rst_rd_len", 32'(rd_if.rd_len), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    sys_rst = 1'b0;
    repeat (5) @(negedge pixel_clk);
    check("idle_no_req", 32'(rd_if.rd_req), 32'd0);

    // First frame: 4 flush cycles, one CHECK cycle, then the request
    vs_pulse();
    clr_cnt = 0;
    req_at  = -1;
    for (int i = 0; i < 12 && req_at < 0; i++) begin
      @(negedge pixel_clk);
      if (fifo_clr) clr_cnt++;
      if (rd_if.rd_req) req_at = i;
    end
    check("f1_clr_cycles", 32'(clr_cnt), 32'd4);
    check("f1_req_latency", 32'(req_at), 32'd5);
    check("f1_addr", 32'(rd_if.rd_addr), 32'd0);
    check("f1_len", 32'(rd_if.rd_len), 32'd256);

    // Level throttling: 900+256 and 769+256 exceed 1024, 768+256 fits
    fifo_level = 11'd900;
    burst(1'b1);
    seen = 0;
    repeat (8) begin
      @(negedge pixel_clk);
      if (rd_if.rd_req) seen = 1;
    end
    check("lvl900_hold", 32'(seen), 32'd0);
    fifo_level = 11'd769;
    @(negedge pixel_clk);
    check("lvl769_hold", 32'(rd_if.rd_req), 32'd0);
    fifo_level = 11'd768;
    @(negedge pixel_clk);
    check("lvl768_req", 32'(rd_if.rd_req), 32'd1);
    check("lvl768_addr", 32'(rd_if.rd_addr), 32'd256);
    fifo_level = '0;

    // Frame start while the burst at offset 512 is in flight
    burst(1'b1);
    wait_req("req512");
    check("addr512", 32'(rd_if.rd_addr), 32'd512);
    burst(1'b0);
    vs_pulse();
    @(negedge pixel_clk);
    check("wait_underrun", 32'(underrun), 32'd1);
    check("wait_req_low", 32'(rd_if.rd_req), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge pixel_clk);
      if (rd_if.rd_req || fifo_clr || underrun) seen = 1;
    end
    check("wait_hold_quiet", 32'(seen), 32'd0);
    rd_if.rd_done = 1'b1;
    @(negedge pixel_clk) rd_if.rd_done = 1'b0;
    check("wait_done_clr", 32'(fifo_clr), 32'd1);
    wait_req("req_restart");
    check("restart_addr", 32'(rd_if.rd_addr), 32'd0);

    // Frame start while requesting, no ack
    vs_pulse();
    check("req_hold_pre", 32'(rd_if.rd_req), 32'd1);
    @(negedge pixel_clk);
    check("req_drop", 32'(rd_if.rd_req), 32'd0);
    check("req_underrun", 32'(underrun), 32'd1);
    check("req_clr", 32'(fifo_clr), 32'd1);
    wait_req("req_after_drop");

    // Bank selection
    @(negedge pixel_clk) begin wr_bank = 1'b1; wr_frame_done = 1'b1; end
    @(negedge pixel_clk) begin wr_frame_done = 1'b0; wr_bank = 1'b0; end
    vs_pulse();
    @(negedge pixel_clk);
    check("bank_switch", 32'(rd_bank), 32'd1);
    wait_req("req_bank1");
    check("bank1_addr", 32'(rd_if.rd_addr), 32'h0010_0000);
    vs_pulse();
    @(negedge pixel_clk);
    check("bank_repeat", 32'(rd_bank), 32'd1);
    wait_req("req_repeat");
    @(negedge pixel_clk) wr_frame_done = 1'b1;
    @(negedge pixel_clk) wr_frame_done = 1'b0;
    vs_pulse();
    @(negedge pixel_clk);
    check("bank_busy_no_switch", 32'(rd_bank), 32'd1);
    wait_req("req_busy");
    @(negedge pixel_clk) wr_bank = 1'b1;
    vs_pulse();
    @(negedge pixel_clk);
    check("bank_late_switch", 32'(rd_bank), 32'd0);

    // Full frame on bank 0 with instant ack/done
    nb = 0; bad = 0; urun = 0;
    last_addr = '0; last_len = '0;
    for (int i = 0; i < 10900; i++) begin
      @(negedge pixel_clk);
      rd_if.rd_done = rd_if.rd_ack;
      rd_if.rd_ack  = rd_if.rd_req;
      if (rd_if.rd_req) begin
        $display("burst addr=%0d len=%0d bank=%0d", rd_if.rd_addr, rd_if.rd_len, rd_bank);
        if (32'(rd_if.rd_addr) != 32'(nb * 256) || rd_if.rd_len != 9'd256) bad++;
        last_addr = 32'(rd_if.rd_addr);
        last_len  = 32'(rd_if.rd_len);
        nb++;
      end
      if (underrun) urun++;
    end
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    check("full_bursts", 32'(nb), 32'd3600);
    check("full_seq_errs", 32'(bad), 32'd0);
    check("full_last_addr", last_addr, 32'd921344);
    check("full_last_len", last_len, 32'd256);
    check("full_underruns", 32'(urun), 32'd0);

    // Frame start from DONE restarts without underrun
    vs_pulse();
    @(negedge pixel_clk);
    check("done_no_underrun", 32'(underrun), 32'd0);
    check("done_clr", 32'(fifo_clr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
